// File: rtl/llsc_monitor.sv
// llsc_monitor: LL/SC link tracker with snoop invalidation, link aging and SC-failure counting
module llsc_monitor #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             ll_req,
  input  logic [31:0]      ll_addr,
  input  logic             sc_req,
  input  logic [31:0]      sc_addr,
  input  logic             snoop_we,
  input  logic [31:0]      snoop_addr,
  output logic             linked,
  output logic [31:0]      link_addr,
  output logic             sc_done,
  output logic             sc_success,
  output logic [CNT_W-1:0] fail_cnt
);
  typedef enum logic {IDLE, LINKED} state_t;
  localparam logic [15:0] AGE_MAX = 16'(TIMEOUT - 1);
  state_t state, state_n;
  logic [15:0] age, age_n;
  logic [31:0] addr_n;
  logic acc_ll, acc_sc, snoop_hit, expiring, done_n, succ_n;
  logic unused_bits;
  assign unused_bits = ^{ll_addr[1:0], sc_addr[1:0], snoop_addr[1:0]};
  assign linked = state == LINKED;
  assign acc_ll = ll_req & ~stall;
  assign acc_sc = sc_req & ~stall;
  assign snoop_hit = linked & snoop_we & (snoop_addr[31:2] == link_addr[31:2]);
  assign expiring = linked & (age == AGE_MAX);
  // next link state and SC outcome; LL beats SC, snoop and timeout, flush beats everything
  always_comb begin
    state_n = state;
    age_n = linked ? age + 16'd1 : age;
    addr_n = link_addr;
    done_n = 1'b0;
    succ_n = 1'b0;
    if (flush) state_n = IDLE;
    else begin
      done_n = acc_sc;
      succ_n = acc_sc & ~acc_ll & linked & (sc_addr[31:2] == link_addr[31:2]) & ~snoop_hit & ~expiring;
      if (acc_ll) begin
        state_n = LINKED;
        age_n = 16'd0;
        addr_n = {ll_addr[31:2], 2'b00};
      end else if (acc_sc | snoop_hit | expiring) state_n = IDLE;
    end
  end
  // registers; the failure count moves on the same edge that raises sc_done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      age <= 16'd0;
      link_addr <= 32'd0;
      sc_done <= 1'b0;
      sc_success <= 1'b0;
      fail_cnt <= '0;
    end else begin
      state <= state_n;
      age <= age_n;
      link_addr <= addr_n;
      sc_done <= done_n;
      sc_success <= succ_n;
      if (done_n & ~succ_n & ~&fail_cnt) fail_cnt <= fail_cnt + CNT_W'(1);
    end
  end
endmodule
